spi_xfer_ctrl: RTL and testbench

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

---
 rtl/spi_xfer_ctrl.sv | 146 ++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer engine: one byte per send_data request, programmable baud, CPOL/CPHA/LSBFE.
// Handles wait-mode freeze and an immediate abort when master mode or run mode is lost.
//
//   state | meaning
//   IDLE  | ss high, sclk tracks cpol, waiting for send_data
//   SETUP | one cycle, ss low, byte loaded, first bit on mosi when cpha=0
//   XFER  | 16 sclk edges, H PCLK cycles each
//   DONE  | one cycle, receive_data pulse, data_miso holds the new byte
module spi_xfer_ctrl (
    input  logic       PCLK,
    input  logic       Preset,
    input  logic       send_data,
    input  logic [7:0] data_mosi,
    input  logic       mstr,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       lsbfe,
    input  logic       spiswai,
    input  logic [1:0] spi_mode,
    input  logic [2:0] sppr,
    input  logic [2:0] spr,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       ss,
    output logic       tip,
    output logic       receive_data,
    output logic [7:0] data_miso
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]  state;
    logic [9:0]  baud_cnt;
    logic [3:0]  edge_cnt;
    logic [7:0]  tx_sr;
    logic [7:0]  rx_sr;
    logic        sclk_r;
    logic        mosi_r;
    logic [7:0]  data_miso_r;

    logic [10:0] half_period;
    logic [10:0] half_m1;
    logic        run_ok;
    logic        abort;
    logic        freeze;
    logic        baud_wrap;
    logic        sample_now;
    logic        next_bit;
    logic [7:0]  tx_shifted;
    logic [7:0]  rx_next;

    // H = (sppr+1) * 2^spr, i.e. half of the divisor (sppr+1) * 2^(spr+1)
    assign half_period = {7'd0, ({1'b0, sppr} + 4'd1)} << spr;
    assign half_m1     = half_period - 11'd1;

    assign run_ok     = mstr && (spi_mode == 2'b00);
    assign abort      = !mstr || spi_mode[1];
    assign freeze     = (spi_mode == 2'b01) && spiswai;
    assign baud_wrap  = ({1'b0, baud_cnt} >= half_m1);
    // even edge samples when cpha=0, odd edge samples when cpha=1
    assign sample_now = (~edge_cnt[0]) ^ cpha;

    assign next_bit   = lsbfe ? tx_sr[0] : tx_sr[7];
    assign tx_shifted = lsbfe ? {1'b0, tx_sr[7:1]} : {tx_sr[6:0], 1'b0};
    assign rx_next    = lsbfe ? {miso, rx_sr[7:1]} : {rx_sr[6:0], miso};

    always_ff @(posedge PCLK or posedge Preset) begin
        if (Preset) begin
            state       <= ST_IDLE;
            baud_cnt    <= '0;
            edge_cnt    <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            sclk_r      <= 1'b0;
            mosi_r      <= 1'b0;
            data_miso_r <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    sclk_r <= cpol;
                    if (send_data && run_ok) begin
                        state    <= ST_SETUP;
                        baud_cnt <= '0;
                        edge_cnt <= '0;
                        rx_sr    <= '0;
                        // data_mosi is only guaranteed valid alongside send_data
                        if (!cpha) begin
                            mosi_r <= lsbfe ? data_mosi[0] : data_mosi[7];
                            tx_sr  <= lsbfe ? {1'b0, data_mosi[7:1]} : {data_mosi[6:0], 1'b0};
                        end else begin
                            tx_sr  <= data_mosi;
                        end
                    end
                end
                ST_SETUP: begin
                    sclk_r <= cpol;
                    state  <= abort ? ST_IDLE : ST_XFER;
                end
                ST_XFER: begin
                    if (abort) begin
                        state  <= ST_IDLE;
                        sclk_r <= cpol;
                    end else if (!freeze) begin
                        if (baud_wrap) begin
                            baud_cnt <= '0;
                            sclk_r   <= ~sclk_r;
                            edge_cnt <= edge_cnt + 4'd1;
                            if (sample_now) begin
                                rx_sr <= rx_next;
                            end else begin
                                mosi_r <= next_bit;
                                tx_sr  <= tx_shifted;
                            end
                            if (edge_cnt == 4'd15) begin
                                state       <= ST_DONE;
                                data_miso_r <= sample_now ? rx_next : rx_sr;
                            end
                        end else begin
                            baud_cnt <= baud_cnt + 10'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    sclk_r <= cpol;
                end
                default: begin
                    state  <= ST_IDLE;
                    sclk_r <= cpol;
                end
            endcase
        end
    end

    assign tip          = (state == ST_SETUP) || (state == ST_XFER);
    assign ss           = ~tip;
    assign receive_data = (state == ST_DONE);
    assign sclk         = sclk_r;
    assign mosi         = mosi_r;
    assign data_miso    = data_miso_r;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: vector table, corner-case sequences and random transfers
// checked against an SPI slave model and arithmetic timing expectations.
module tb_spi_xfer_ctrl;

    logic       PCLK = 1'b0;
    logic       Preset;
    logic       send_data;
    logic [7:0] data_mosi;
    logic       mstr, cpol, cpha, lsbfe, spiswai;
    logic [1:0] spi_mode;
    logic [2:0] sppr, spr;
    wire        miso;
    logic       sclk, mosi, ss, tip, receive_data;
    logic [7:0] data_miso;

    logic       loopback;
    logic       slv_miso;

    assign miso = loopback ? mosi : slv_miso;

    always #5 PCLK = ~PCLK;

    spi_xfer_ctrl dut (
        .PCLK(PCLK), .Preset(Preset), .send_data(send_data), .data_mosi(data_mosi),
        .mstr(mstr), .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe), .spiswai(spiswai),
        .spi_mode(spi_mode), .sppr(sppr), .spr(spr), .miso(miso),
        .sclk(sclk), .mosi(mosi), .ss(ss), .tip(tip), .receive_data(receive_data),
        .data_miso(data_miso)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // bus monitor
    int         mon_tip, mon_rx, mon_edges;
    logic       mon_last_sclk;
    logic [7:0] mon_rx_data;

    always @(negedge PCLK) begin
        if (tip === 1'b1) mon_tip++;
        if (receive_data === 1'b1) begin
            mon_rx++;
            mon_rx_data = data_miso;
        end
        if (sclk !== mon_last_sclk) mon_edges++;
        mon_last_sclk = sclk;
    end

    // SPI slave: shifts slv_tx out on miso, captures mosi into slv_rx
    logic [7:0] slv_tx, slv_rx;
    int         slv_edges;
    logic       slv_active, slv_last;

    function automatic int bit_pos(input int n);
        return lsbfe ? n : 7 - n;
    endfunction

    always @(negedge PCLK) begin
        if (slv_active && sclk !== slv_last && slv_edges < 16) begin
            slv_last = sclk;
            if (!cpha) begin
                if (slv_edges % 2 == 0) slv_rx[bit_pos(slv_edges / 2)] = mosi;
                else if (slv_edges / 2 < 7) slv_miso = slv_tx[bit_pos(slv_edges / 2 + 1)];
            end else begin
                if (slv_edges % 2 == 0) slv_miso = slv_tx[bit_pos(slv_edges / 2)];
                else slv_rx[bit_pos(slv_edges / 2)] = mosi;
            end
            slv_edges++;
        end
        if (ss !== 1'b0) begin
            slv_active = 1'b0;
        end else if (!slv_active) begin
            slv_active = 1'b1;
            slv_edges  = 0;
            slv_last   = sclk;
            slv_rx     = 8'h00;
            if (!cpha) slv_miso = slv_tx[bit_pos(0)];
        end
    end

    task automatic tick();
        @(negedge PCLK);
        #1;
    endtask

    task automatic mon_clear();
        mon_tip = 0; mon_rx = 0; mon_edges = 0; mon_last_sclk = sclk; mon_rx_data = 8'h00;
    endtask

    task automatic start(input logic [7:0] d);
        data_mosi = d;
        send_data = 1'b1;
        tick();
        send_data = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (tip && n < 20000) begin
            tick();
            n++;
        end
        if (tip) begin
            n_total++;
            $display("FAIL %s_timeout: tip still high after %0d cycles, expected low", name, n);
        end
        repeat (3) tick();
    endtask

    typedef struct {
        logic       cpol, cpha, lsbfe, loop_en;
        logic [2:0] sppr, spr;
        logic [7:0] data, slv_byte, exp_miso;
        int         exp_tip;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input string name, input vec_t v);
        cpol = v.cpol; cpha = v.cpha; lsbfe = v.lsbfe; loopback = v.loop_en;
        sppr = v.sppr; spr = v.spr; slv_tx = v.slv_byte;
        tick(); tick();
        mon_clear();
        check({name, "_sclk_idle"}, sclk, v.cpol);
        start(v.data);
        wait_idle(name);
        check({name, "_tip_cycles"}, mon_tip, v.exp_tip);
        check({name, "_sclk_edges"}, mon_edges, 16);
        check({name, "_rx_pulses"}, mon_rx, 1);
        check({name, "_miso_at_pulse"}, mon_rx_data, v.exp_miso);
        check({name, "_data_miso"}, data_miso, v.exp_miso);
        check({name, "_slave_rx"}, slv_rx, v.data);
    endtask

    initial begin
        logic [7:0] prev_miso;
        logic       frz_sclk;
        int         frz_edges, sclk_changes, n;
        vec_t       rv;

        Preset = 1'b1; send_data = 1'b0; data_mosi = 8'h00;
        mstr = 1'b1; cpol = 1'b1; cpha = 1'b0; lsbfe = 1'b0; spiswai = 1'b0;
        spi_mode = 2'b00; sppr = 3'd0; spr = 3'd0;
        loopback = 1'b1; slv_miso = 1'b0; slv_tx = 8'h00; slv_rx = 8'h00;
        slv_active = 1'b0; slv_edges = 0; slv_last = 1'b0;
        mon_tip = 0; mon_rx = 0; mon_edges = 0; mon_last_sclk = 1'b0; mon_rx_data = 8'h00;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 8'hA5, 8'h00, 8'hA5, 17};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 3'd1, 8'h3C, 8'h00, 8'h3C, 97};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd2, 8'h81, 8'h7E, 8'h7E, 65};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 3'd0, 8'h0F, 8'hC3, 8'hC3, 33};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 3'd7, 8'h96, 8'h69, 8'h69, 16385};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 8'hD2, 8'h2B, 8'h2B, 17};

        // reset values, with cpol=1 to show sclk is forced low
        tick(); tick();
        check("rst_ss", ss, 1'b1);
        check("rst_tip", tip, 1'b0);
        check("rst_sclk", sclk, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_receive", receive_data, 1'b0);
        check("rst_data_miso", data_miso, 8'h00);
        Preset = 1'b0;
        tick();
        check("post_rst_sclk_cpol", sclk, 1'b1);
        cpol = 1'b0;
        tick();
        check("idle_cpol_follow", sclk, 1'b0);

        // requests that must not start a transfer
        mon_clear();
        mstr = 1'b0; start(8'hFF); mstr = 1'b1;
        spi_mode = 2'b10; start(8'hFF);
        spi_mode = 2'b11; start(8'hFF);
        spi_mode = 2'b01; start(8'hFF);
        spi_mode = 2'b00;
        repeat (3) tick();
        check("ignored_send_tip", mon_tip, 0);
        check("ignored_send_ss", ss, 1'b1);

        for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // second request mid-transfer is dropped
        cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; sppr = 3'd0; spr = 3'd0; loopback = 1'b1;
        tick();
        mon_clear();
        start(8'hC6);
        repeat (5) tick();
        data_mosi = 8'h11; send_data = 1'b1; tick(); send_data = 1'b0;
        wait_idle("double_send");
        repeat (10) tick();
        check("double_send_tip", mon_tip, 17);
        check("double_send_rx", mon_rx, 1);
        check("double_send_data", data_miso, 8'hC6);

        // wait-mode freeze for 20 cycles
        mon_clear();
        start(8'h4B);
        repeat (4) tick();
        spi_mode = 2'b01; spiswai = 1'b1;
        frz_sclk = sclk; frz_edges = mon_edges; sclk_changes = 0;
        repeat (20) begin
            tick();
            if (sclk !== frz_sclk) sclk_changes++;
        end
        check("freeze_sclk_changes", sclk_changes, 0);
        check("freeze_edges", mon_edges, frz_edges);
        check("freeze_tip", tip, 1'b1);
        spi_mode = 2'b00; spiswai = 1'b0;
        wait_idle("freeze");
        check("freeze_tip_cycles", mon_tip, 37);
        check("freeze_sclk_edges", mon_edges, 16);
        check("freeze_rx", mon_rx, 1);
        check("freeze_data", data_miso, 8'h4B);

        // mstr dropped after edge 8
        prev_miso = 8'h4B;
        cpol = 1'b1; tick(); tick();
        mon_clear();
        start(8'hE7);
        n = 0;
        while (mon_edges < 8 && n < 100) begin tick(); n++; end
        check("abort_reach_edge8", mon_edges, 8);
        mstr = 1'b0;
        tick();
        check("abort_ss", ss, 1'b1);
        check("abort_tip", tip, 1'b0);
        check("abort_sclk", sclk, 1'b1);
        mstr = 1'b1;
        repeat (5) tick();
        check("abort_rx", mon_rx, 0);
        check("abort_data_kept", data_miso, prev_miso);

        // reset mid-transfer
        cpol = 1'b0; cpha = 1'b1; sppr = 3'd1; spr = 3'd0;
        tick(); tick();
        mon_clear();
        start(8'h99);
        repeat (10) tick();
        Preset = 1'b1;
        #1;
        check("midrst_ss", ss, 1'b1);
        check("midrst_tip", tip, 1'b0);
        check("midrst_sclk", sclk, 1'b0);
        check("midrst_mosi", mosi, 1'b0);
        check("midrst_receive", receive_data, 1'b0);
        check("midrst_data_miso", data_miso, 8'h00);
        cpol = 1'b1;
        repeat (3) tick();
        Preset = 1'b0;
        tick();
        check("midrst_sclk_cpol", sclk, 1'b1);
        check("midrst_rx", mon_rx, 0);
        rv = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 3'd0, 8'h5A, 8'h00, 8'h5A, 33};
        run_vec("after_rst", rv);

        // random configurations; timing from H = (sppr+1)*2^(spr+1)/2
        for (int i = 0; i < 12; i++) begin
            int p, r, h;
            p = $urandom_range(0, 3);
            r = $urandom_range(0, 2);
            h = (p + 1) * (1 << (r + 1)) / 2;
            rv.cpol     = 1'($urandom_range(0, 1));
            rv.cpha     = 1'($urandom_range(0, 1));
            rv.lsbfe    = 1'($urandom_range(0, 1));
            rv.loop_en  = 1'($urandom_range(0, 1));
            rv.sppr     = 3'(p);
            rv.spr      = 3'(r);
            rv.data     = 8'($urandom_range(0, 255));
            rv.slv_byte = 8'($urandom_range(0, 255));
            rv.exp_miso = rv.loop_en ? rv.data : rv.slv_byte;
            rv.exp_tip  = 1 + 16 * h;
            run_vec($sformatf("rand%0d", i), rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
